// File: rtl/aurora_rx_pkg.sv
// Shared types and helpers for the aurora_rx lane: block-sync FSM states and
// 64b/66b sync header encodings.
package aurora_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        SLIP   = 3'd2,
        WAIT   = 3'd3,
        LOCKED = 3'd4
    } sync_state_t;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    function automatic logic is_valid_header(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/aurora_rx_block_sync_if.sv
// Gearbox <-> block-sync link: qualified sync headers in, slip pulses out.
interface aurora_rx_block_sync_if;

    logic [1:0] header_i;
    logic       header_valid_i;
    logic       gearbox_slip_o;
    logic       serdes_slip_o;

    modport master (
        output header_i,
        output header_valid_i,
        input  gearbox_slip_o,
        input  serdes_slip_o
    );

    modport slave (
        input  header_i,
        input  header_valid_i,
        output gearbox_slip_o,
        output serdes_slip_o
    );

endinterface

// File: rtl/aurora_rx_block_sync.sv
// 64b/66b block-alignment controller: slips gearbox/serdes until sync headers
// line up, then declares and monitors lane lock.
module aurora_rx_block_sync
    import aurora_rx_pkg::*;
#(
    parameter int unsigned SH_CNT_MAX       = 64,
    parameter int unsigned SH_INVLD_CNT_MAX = 16,
    parameter int unsigned SLIP_WAIT        = 16,
    parameter int unsigned GBOX_SLIPS_MAX   = 66
) (
    input  logic                         clk_rx_i,
    input  logic                         rst_n_i,
    input  logic                         enable_i,
    aurora_rx_block_sync_if.slave        gbx,
    output logic                         locked_o,
    output logic [7:0]                   lock_loss_cnt_o,
    output logic [7:0]                   stat_o
);

    localparam int unsigned SH_W   = $clog2(SH_CNT_MAX) + 1;
    localparam int unsigned INV_W  = $clog2(SH_INVLD_CNT_MAX) + 1;
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT) + 1;
    localparam int unsigned GBOX_W = $clog2(GBOX_SLIPS_MAX) + 1;

    sync_state_t       state, state_n;
    logic [SH_W-1:0]   sh_cnt, sh_n;
    logic [INV_W-1:0]  inv_cnt, inv_n;
    logic [WAIT_W-1:0] wait_cnt, wait_n;
    logic [GBOX_W-1:0] gbox_cnt, gbox_n;
    logic              locked_n, gslip_n, sslip_n;
    logic [7:0]        loss_n, stat_n;
    logic              hdr_ok, sample, enter_slip;
    logic [SH_W-1:0]   sh_inc;
    logic [INV_W-1:0]  inv_inc;

    // Next-state, counter and registered-output logic
    always_comb begin
        state_n    = state;
        sh_n       = sh_cnt;
        inv_n      = inv_cnt;
        wait_n     = wait_cnt;
        gbox_n     = gbox_cnt;
        locked_n   = locked_o;
        loss_n     = lock_loss_cnt_o;
        gslip_n    = 1'b0;
        sslip_n    = 1'b0;
        enter_slip = 1'b0;
        hdr_ok     = is_valid_header(gbx.header_i);
        sample     = gbx.header_valid_i && ((state == SEARCH) || (state == LOCKED));
        sh_inc     = sh_cnt + SH_W'(1);
        inv_inc    = inv_cnt + INV_W'(~hdr_ok);

        if (!enable_i) begin
            state_n  = IDLE;
            sh_n     = '0;
            inv_n    = '0;
            wait_n   = '0;
            gbox_n   = '0;
            locked_n = 1'b0;
        end else begin
            case (state)
                IDLE: state_n = SEARCH;
                SEARCH: begin
                    if (sample) begin
                        if (!hdr_ok) begin
                            enter_slip = 1'b1;
                        end else if (sh_inc == SH_W'(SH_CNT_MAX)) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            sh_n     = '0;
                            inv_n    = '0;
                            gbox_n   = '0;
                        end else begin
                            sh_n = sh_inc;
                        end
                    end
                end
                SLIP: begin
                    state_n = WAIT;
                    wait_n  = '0;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                        state_n = SEARCH;
                        wait_n  = '0;
                    end else begin
                        wait_n = wait_cnt + WAIT_W'(1);
                    end
                end
                LOCKED: begin
                    if (sample) begin
                        // Invalid-limit check first so loss of lock wins at window end
                        if (inv_inc == INV_W'(SH_INVLD_CNT_MAX)) begin
                            locked_n   = 1'b0;
                            loss_n     = (lock_loss_cnt_o == 8'hFF) ? lock_loss_cnt_o
                                                                    : lock_loss_cnt_o + 8'd1;
                            enter_slip = 1'b1;
                        end else if (sh_inc == SH_W'(SH_CNT_MAX)) begin
                            sh_n  = '0;
                            inv_n = '0;
                        end else begin
                            sh_n  = sh_inc;
                            inv_n = inv_inc;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Slip pulse is registered on entry so it coincides with the SLIP cycle
        if (enter_slip) begin
            state_n = SLIP;
            sh_n    = '0;
            inv_n   = '0;
            if (gbox_cnt < GBOX_W'(GBOX_SLIPS_MAX - 1)) begin
                gslip_n = 1'b1;
                gbox_n  = gbox_cnt + GBOX_W'(1);
            end else begin
                sslip_n = 1'b1;
                gbox_n  = '0;
            end
        end

        stat_n = {locked_n, 3'(state_n), gbox_n[6:3]};
    end

    // State, counters and outputs
    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state              <= IDLE;
            sh_cnt             <= '0;
            inv_cnt            <= '0;
            wait_cnt           <= '0;
            gbox_cnt           <= '0;
            locked_o           <= 1'b0;
            lock_loss_cnt_o    <= '0;
            stat_o             <= '0;
            gbx.gearbox_slip_o <= 1'b0;
            gbx.serdes_slip_o  <= 1'b0;
        end else begin
            state              <= state_n;
            sh_cnt             <= sh_n;
            inv_cnt            <= inv_n;
            wait_cnt           <= wait_n;
            gbox_cnt           <= gbox_n;
            locked_o           <= locked_n;
            lock_loss_cnt_o    <= loss_n;
            stat_o             <= stat_n;
            gbx.gearbox_slip_o <= gslip_n;
            gbx.serdes_slip_o  <= sslip_n;
        end
    end

endmodule

// File: tb/tb_aurora_rx_block_sync.sv
// Directed bench for aurora_rx_block_sync: lock, slip sequencing, lock loss,
// enable and reset handling.
module tb_aurora_rx_block_sync;

    logic       clk_rx_i = 1'b0;
    logic       rst_n_i;
    logic       enable_i;
    logic       locked_o;
    logic [7:0] lock_loss_cnt_o;
    logic [7:0] stat_o;

    int total = 0;
    int bad   = 0;
    int gcnt  = 0;
    int scnt  = 0;
    int ovl   = 0;
    int g0, s0;

    aurora_rx_block_sync_if gbx_if ();

    aurora_rx_block_sync dut (
        .clk_rx_i        (clk_rx_i),
        .rst_n_i         (rst_n_i),
        .enable_i        (enable_i),
        .gbx             (gbx_if),
        .locked_o        (locked_o),
        .lock_loss_cnt_o (lock_loss_cnt_o),
        .stat_o          (stat_o)
    );

    always #5 clk_rx_i = ~clk_rx_i;

    // Pulse counters sampled mid-cycle
    always @(negedge clk_rx_i) begin
        if (gbx_if.gearbox_slip_o) gcnt++;
        if (gbx_if.serdes_slip_o)  scnt++;
        if (gbx_if.gearbox_slip_o && gbx_if.serdes_slip_o) ovl++;
    end

    task automatic tick();
        @(posedge clk_rx_i);
        #1;
    endtask

    task automatic send(input logic [1:0] hdr);
        gbx_if.header_i       = hdr;
        gbx_if.header_valid_i = 1'b1;
        tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] vhdr(input int i);
        return (i % 2 == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] ihdr(input int i);
        return (i % 2 == 1) ? 2'b11 : 2'b00;
    endfunction

    initial begin
        rst_n_i               = 1'b0;
        enable_i              = 1'b0;
        gbx_if.header_i       = 2'b00;
        gbx_if.header_valid_i = 1'b0;
        tick();
        tick();
        chk("rst_locked", 8'(locked_o), 8'd0);
        chk("rst_gslip", 8'(gbx_if.gearbox_slip_o), 8'd0);
        chk("rst_sslip", 8'(gbx_if.serdes_slip_o), 8'd0);
        chk("rst_loss", lock_loss_cnt_o, 8'd0);
        chk("rst_stat", stat_o, 8'h00);

        rst_n_i = 1'b1;
        tick();
        chk("idle_disabled", stat_o, 8'h00);
        enable_i = 1'b1;
        tick();
        chk("search_entry", stat_o, 8'h10);

        // Aligned stream: lock one cycle after the 64th valid header
        g0 = gcnt;
        s0 = scnt;
        for (int i = 0; i < 64; i++) begin
            send(vhdr(i));
            if (i == 62) chk("aligned_pre_lock", 8'(locked_o), 8'd0);
        end
        chk("aligned_lock", 8'(locked_o), 8'd1);
        chk("aligned_stat", stat_o, 8'hC0);
        chk("aligned_no_gslip", 8'(gcnt - g0), 8'd0);
        chk("aligned_no_sslip", 8'(scnt - s0), 8'd0);

        enable_i              = 1'b0;
        gbx_if.header_valid_i = 1'b0;
        tick();
        chk("dis_unlock", 8'(locked_o), 8'd0);
        chk("dis_stat", stat_o, 8'h00);
        enable_i = 1'b1;
        tick();
        chk("reen_search", stat_o, 8'h10);

        // Five-bit offset: five slips, each followed by an ignored settle period
        g0 = gcnt;
        for (int k = 0; k < 5; k++) begin
            send(ihdr(k));
            chk("ofs_gslip", 8'(gbx_if.gearbox_slip_o), 8'd1);
            chk("ofs_sslip", 8'(gbx_if.serdes_slip_o), 8'd0);
            if (k == 0) chk("ofs_slip_stat", stat_o, 8'h20);
            for (int j = 1; j <= 17; j++) begin
                send(ihdr(j));
                if (k == 0 && j == 16) chk("ofs_wait_stat", stat_o, 8'h30);
                if (k == 0 && j == 17) chk("ofs_search_stat", stat_o, 8'h10);
            end
        end
        chk("ofs_gslip_count", 8'(gcnt - g0), 8'd5);
        for (int i = 0; i < 64; i++) begin
            send(vhdr(i));
            if (i == 62) chk("ofs_pre_lock", 8'(locked_o), 8'd0);
        end
        chk("ofs_lock", 8'(locked_o), 8'd1);
        chk("ofs_lock_stat", stat_o, 8'hC0);

        // Window with 15 invalid headers keeps lock
        for (int i = 0; i < 64; i++) send((i < 15) ? ihdr(i) : vhdr(i));
        chk("win15_locked", 8'(locked_o), 8'd1);
        chk("win15_loss", lock_loss_cnt_o, 8'd0);

        // 16th invalid header lands on the 64th header of the window
        for (int i = 0; i < 64; i++) begin
            send((i < 15 || i == 63) ? ihdr(i) : vhdr(i));
            if (i == 62) chk("win16_pre_locked", 8'(locked_o), 8'd1);
        end
        chk("win16_unlock", 8'(locked_o), 8'd0);
        chk("win16_loss", lock_loss_cnt_o, 8'd1);
        chk("win16_gslip", 8'(gbx_if.gearbox_slip_o), 8'd1);
        chk("win16_sslip", 8'(gbx_if.serdes_slip_o), 8'd0);
        chk("win16_stat", stat_o, 8'h20);
        send(vhdr(0));
        chk("win16_pulse_end", 8'(gbx_if.gearbox_slip_o), 8'd0);
        chk("win16_wait_stat", stat_o, 8'h30);

        // Relock, then drop enable while locked
        for (int j = 2; j <= 17; j++) send(vhdr(j));
        for (int i = 0; i < 64; i++) send(vhdr(i));
        chk("relock", 8'(locked_o), 8'd1);
        enable_i              = 1'b0;
        gbx_if.header_valid_i = 1'b0;
        tick();
        chk("dis2_unlock", 8'(locked_o), 8'd0);
        chk("dis2_loss_held", lock_loss_cnt_o, 8'd1);
        chk("dis2_stat", stat_o, 8'h00);
        enable_i = 1'b1;
        tick();

        // 67 slip attempts: 65 gearbox, one serdes, then gearbox again
        g0 = gcnt;
        s0 = scnt;
        for (int k = 1; k <= 67; k++) begin
            send(ihdr(k));
            chk("seq_gslip", 8'(gbx_if.gearbox_slip_o), (k != 66) ? 8'd1 : 8'd0);
            chk("seq_sslip", 8'(gbx_if.serdes_slip_o), (k == 66) ? 8'd1 : 8'd0);
            if (k == 65) chk("seq_stat65", stat_o, 8'h28);
            if (k == 66) chk("seq_stat66", stat_o, 8'h20);
            for (int j = 1; j <= 17; j++) send(ihdr(j));
        end
        chk("seq_gslip_total", 8'(gcnt - g0), 8'd66);
        chk("seq_sslip_total", 8'(scnt - s0), 8'd1);
        chk("slip_overlap", 8'(ovl), 8'd0);

        // Asynchronous reset during a slip pulse
        send(ihdr(0));
        chk("pre_rst_gslip", 8'(gbx_if.gearbox_slip_o), 8'd1);
        rst_n_i = 1'b0;
        #1;
        chk("arst_gslip", 8'(gbx_if.gearbox_slip_o), 8'd0);
        chk("arst_sslip", 8'(gbx_if.serdes_slip_o), 8'd0);
        chk("arst_locked", 8'(locked_o), 8'd0);
        chk("arst_loss", lock_loss_cnt_o, 8'd0);
        chk("arst_stat", stat_o, 8'h00);
        gbx_if.header_valid_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        tick();
        chk("post_rst_search", stat_o, 8'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
